// File: rtl/siso_tx_ctrl_pkg.sv
// Shared constants for the serial transmit controller: FSM encoding and
// default frame geometry.
package siso_tx_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int WIDTH_DEF = 4;
  localparam int GAP_DEF   = 1;

  // Width of the gap counter; a zero gap still needs a legal 1-bit vector.
  function automatic int gap_cnt_width(input int gap);
    return (gap > 0) ? (($clog2(gap + 1) > 0) ? $clog2(gap + 1) : 1) : 1;
  endfunction

endpackage

// File: rtl/siso_shift_core.sv
// WIDTH-bit right-shift register, zero-filled at the MSB, LSB driven on so.
// Load has priority over shift so a new word can chain onto the last bit.
module siso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             so
);

  logic [WIDTH-1:0] sreg_r;

  // Shift register: clear, parallel load, or right shift.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sreg_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sreg_r <= din;
    end else if (shift_en) begin
      sreg_r <= {1'b0, sreg_r[WIDTH-1:1]};
    end else begin
      sreg_r <= sreg_r;
    end
  end

  assign so = sreg_r[0];

endmodule

// File: rtl/siso_tx_ctrl.sv
// Serial transmit sequencer: accepts parallel words over valid/ready, shifts
// them out LSB-first with sof/eof strobes, pause stalls and an idle gap.
module siso_tx_ctrl
  import siso_tx_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             pause,
  output logic             so,
  output logic             so_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int BCW      = $clog2(WIDTH);
  localparam int GCW      = gap_cnt_width(GAP);
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  logic [1:0]     state_r;
  logic [BCW-1:0] bit_cnt_r;
  logic [GCW-1:0] gap_cnt_r;

  logic last_bit_s;
  logic accept_s;
  logic shift_en_s;
  logic core_so_s;

  assign last_bit_s = (state_r == ST_SHIFT) && (bit_cnt_r == BCW'(WIDTH - 1));
  assign accept_s   = in_valid && in_ready;
  assign shift_en_s = clear_n && (state_r == ST_SHIFT) && !pause;

  siso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .clear_n  (clear_n),
    .load     (accept_s),
    .shift_en (shift_en_s),
    .din      (in_data),
    .so       (core_so_s)
  );

  // Output decode; everything is forced low while clear_n is asserted.
  always_comb begin
    in_ready = 1'b0;
    so       = 1'b0;
    so_valid = 1'b0;
    sof      = 1'b0;
    eof      = 1'b0;
    busy     = 1'b0;
    if (!clear_n) begin
      in_ready = 1'b0;
    end else begin
      busy = (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          in_ready = 1'b1;
        end
        ST_SHIFT: begin
          // Chaining is only possible with no gap and a non-stalled last bit.
          in_ready = last_bit_s && !pause && (GAP == 0);
          so       = core_so_s;
          so_valid = !pause;
          sof      = !pause && (bit_cnt_r == {BCW{1'b0}});
          eof      = !pause && last_bit_s;
        end
        ST_GAP: begin
          in_ready = 1'b0;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

  // FSM and counters; pause freezes SHIFT only, GAP keeps counting.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= {BCW{1'b0}};
      gap_cnt_r <= {GCW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_SHIFT;
            bit_cnt_r <= {BCW{1'b0}};
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (pause) begin
            state_r <= ST_SHIFT;
          end else if (last_bit_s) begin
            bit_cnt_r <= {BCW{1'b0}};
            if (GAP > 0) begin
              state_r   <= ST_GAP;
              gap_cnt_r <= {GCW{1'b0}};
            end else if (accept_s) begin
              state_r <= ST_SHIFT;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + BCW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GCW'(GAP_LAST)) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= {GCW{1'b0}};
          end else begin
            gap_cnt_r <= gap_cnt_r + GCW'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= {BCW{1'b0}};
          gap_cnt_r <= {GCW{1'b0}};
        end
      endcase
    end
  end

endmodule
